// File: rtl/uart_reg_master_pkg.sv
// Shared types and constants for the UART-driven register bus master.
package uart_reg_master_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CMD_WR_BIT = 7;
  localparam int unsigned ST_W       = 5;

  // Bit positions of the one-hot state vector; strobes are decoded straight from these.
  localparam int unsigned IDX_IDLE  = 0;
  localparam int unsigned IDX_WDAT  = 1;
  localparam int unsigned IDX_WRITE = 2;
  localparam int unsigned IDX_READ  = 3;
  localparam int unsigned IDX_TX    = 4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = 5'b00001,
    S_WDAT  = 5'b00010,
    S_WRITE = 5'b00100,
    S_READ  = 5'b01000,
    S_TX    = 5'b10000
  } state_e;

  function automatic int unsigned to_cnt_w(input int unsigned cyc);
    return (cyc < 1) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/uart_reg_master_to.sv
// Inter-byte timeout counter: counts enabled cycles and flags expiry of the write-data wait.
module uart_reg_master_to
  import uart_reg_master_pkg::*;
#(
  parameter int unsigned C_TO_CYC = 4095
) (
  input  logic CK_i,
  input  logic XARST_i,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CNT_W = to_cnt_w(C_TO_CYC);
  // Expiry fires on the cycle whose increment would bring the count to C_TO_CYC-1.
  localparam int unsigned TGT   = (C_TO_CYC >= 2) ? C_TO_CYC - 2 : 0;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = (C_TO_CYC != 0) && i_en && (r_cnt == CNT_W'(TGT));

endmodule

// File: rtl/uart_reg_master.sv
// Byte-stream command decoder that masters the register bank and returns read data to UART TX.
module uart_reg_master
  import uart_reg_master_pkg::*;
#(
  parameter int unsigned C_ADR_W   = 4,
  parameter int unsigned C_TO_CYC  = 4095,
  parameter int unsigned C_WR_ECHO = 0
) (
  input  logic               CK_i,
  input  logic               XARST_i,
  input  logic [BYTE_W-1:0]  RX_BYTEs_i,
  input  logic               RX_DONE_i,
  output logic [C_ADR_W-1:0] ADRs_o,
  output logic [BYTE_W-1:0]  WDATs_o,
  output logic               WT_o,
  output logic               RD_o,
  input  logic [BYTE_W-1:0]  RDATs_i,
  output logic [BYTE_W-1:0]  TX_BYTEs_o,
  output logic               TX_REQ_o,
  input  logic               TX_ACK_i,
  output logic               ERR_o
);

  state_e              r_state, w_state_d;
  logic [C_ADR_W-1:0]  r_adr, w_adr_d;
  logic [BYTE_W-1:0]   r_wdat, w_wdat_d;
  logic [BYTE_W-1:0]   r_tx_byte, w_tx_byte_d;
  logic                r_tx_req;
  logic                r_err, w_err_d;
  logic                w_cmd_ok;
  logic                w_to_clr;
  logic                w_to_en;
  logic                w_expire;

  // Bits between the address field and the R/W bit are reserved and must be zero.
  assign w_cmd_ok = ((RX_BYTEs_i[6:0] >> C_ADR_W) == 7'd0);
  assign w_to_clr = ~r_state[IDX_WDAT];
  assign w_to_en  = r_state[IDX_WDAT] & ~RX_DONE_i;

  uart_reg_master_to #(
    .C_TO_CYC (C_TO_CYC)
  ) u_to (
    .CK_i     (CK_i),
    .XARST_i  (XARST_i),
    .i_clr    (w_to_clr),
    .i_en     (w_to_en),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_d   = r_state;
    w_adr_d     = r_adr;
    w_wdat_d    = r_wdat;
    w_tx_byte_d = r_tx_byte;
    w_err_d     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (RX_DONE_i) begin
          if (w_cmd_ok) begin
            w_adr_d   = RX_BYTEs_i[C_ADR_W-1:0];
            w_state_d = RX_BYTEs_i[CMD_WR_BIT] ? S_WDAT : S_READ;
          end else begin
            w_err_d = 1'b1;
          end
        end
      end
      S_WDAT: begin
        if (RX_DONE_i) begin
          w_wdat_d  = RX_BYTEs_i;
          w_state_d = S_WRITE;
        end else if (w_expire) begin
          w_err_d   = 1'b1;
          w_state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        w_err_d = RX_DONE_i;
        if (C_WR_ECHO != 0) begin
          w_tx_byte_d = r_wdat;
          w_state_d   = S_TX;
        end else begin
          w_state_d = S_IDLE;
        end
      end
      S_READ: begin
        w_err_d     = RX_DONE_i;
        w_tx_byte_d = RDATs_i;
        w_state_d   = S_TX;
      end
      S_TX: begin
        w_err_d = RX_DONE_i;
        if (TX_ACK_i) begin
          w_state_d = S_IDLE;
        end
      end
      default: begin
        w_state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_state   <= S_IDLE;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_tx_byte <= '0;
      r_tx_req  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_adr     <= w_adr_d;
      r_wdat    <= w_wdat_d;
      r_tx_byte <= w_tx_byte_d;
      r_tx_req  <= (w_state_d == S_TX);
      r_err     <= w_err_d;
    end
  end

  assign ADRs_o     = r_adr;
  assign WDATs_o    = r_wdat;
  assign WT_o       = r_state[IDX_WRITE];
  assign RD_o       = r_state[IDX_READ];
  assign TX_BYTEs_o = r_tx_byte;
  assign TX_REQ_o   = r_tx_req;
  assign ERR_o      = r_err;

endmodule

// File: tb/tb_uart_reg_master.sv
// Bench for uart_reg_master: directed plus randomized transactions against a register-bank model.
module tb_uart_reg_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rx_byte = 8'h00;
  logic       rx_done0 = 1'b0, rx_done1 = 1'b0;
  logic       tx_ack0 = 1'b0, tx_ack1 = 1'b0;
  logic [3:0] adr0;
  logic [4:0] adr1;
  logic [7:0] wdat0, wdat1, rdat0, rdat1, txb0, txb1;
  logic       wt0, wt1, rd0, rd1, txr0, txr1, err0, err1;

  uart_reg_master #(.C_ADR_W(4), .C_TO_CYC(16), .C_WR_ECHO(0)) dut0 (
    .CK_i(clk), .XARST_i(rst_n), .RX_BYTEs_i(rx_byte), .RX_DONE_i(rx_done0),
    .ADRs_o(adr0), .WDATs_o(wdat0), .WT_o(wt0), .RD_o(rd0), .RDATs_i(rdat0),
    .TX_BYTEs_o(txb0), .TX_REQ_o(txr0), .TX_ACK_i(tx_ack0), .ERR_o(err0)
  );

  uart_reg_master #(.C_ADR_W(5), .C_TO_CYC(16), .C_WR_ECHO(1)) dut1 (
    .CK_i(clk), .XARST_i(rst_n), .RX_BYTEs_i(rx_byte), .RX_DONE_i(rx_done1),
    .ADRs_o(adr1), .WDATs_o(wdat1), .WT_o(wt1), .RD_o(rd1), .RDATs_i(rdat1),
    .TX_BYTEs_o(txb1), .TX_REQ_o(txr1), .TX_ACK_i(tx_ack1), .ERR_o(err1)
  );

  function automatic logic [7:0] bank_init(input int i);
    return 8'((i * 29 + 7) ^ 165);
  endfunction

  // Register bank models: combinational read, written on WT_o.
  logic [7:0] bank0 [16];
  logic [7:0] bank1 [32];
  assign rdat0 = bank0[adr0];
  assign rdat1 = bank1[adr1];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) bank0[i] <= bank_init(i);
      for (int i = 0; i < 32; i++) bank1[i] <= bank_init(i);
    end else begin
      if (wt0) bank0[adr0] <= wdat0;
      if (wt1) bank1[adr1] <= wdat1;
    end
  end

  // Strobe counters observed on the bus.
  int n_wt [2] = '{0, 0};
  int n_rd [2] = '{0, 0};
  int n_er [2] = '{0, 0};
  int n_both = 0;
  always @(posedge clk) begin
    if (wt0) n_wt[0] <= n_wt[0] + 1;
    if (wt1) n_wt[1] <= n_wt[1] + 1;
    if (rd0) n_rd[0] <= n_rd[0] + 1;
    if (rd1) n_rd[1] <= n_rd[1] + 1;
    if (err0) n_er[0] <= n_er[0] + 1;
    if (err1) n_er[1] <= n_er[1] + 1;
    if ((wt0 && rd0) || (wt1 && rd1)) n_both <= n_both + 1;
  end

  // Reference model state.
  logic [7:0] ref0 [16];
  logic [7:0] ref1 [32];
  int exp_wt [2] = '{0, 0};
  int exp_rd [2] = '{0, 0};
  int exp_er [2] = '{0, 0};

  int n_chk = 0;
  int n_err = 0;

  logic       sel = 1'b0;
  logic       wt_s, rd_s, txr_s, err_s;
  logic [4:0] adr_s;
  logic [7:0] wdat_s, txb_s;
  assign wt_s   = sel ? wt1 : wt0;
  assign rd_s   = sel ? rd1 : rd0;
  assign txr_s  = sel ? txr1 : txr0;
  assign err_s  = sel ? err1 : err0;
  assign adr_s  = sel ? adr1 : {1'b0, adr0};
  assign wdat_s = sel ? wdat1 : wdat0;
  assign txb_s  = sel ? txb1 : txb0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge one cycle after the byte was sampled.
  task automatic send(input logic s, input logic [7:0] b);
    sel = s;
    @(negedge clk);
    rx_byte = b;
    if (s) rx_done1 = 1'b1;
    else   rx_done0 = 1'b1;
    @(negedge clk);
    rx_done0 = 1'b0;
    rx_done1 = 1'b0;
  endtask

  task automatic do_ack(input logic s, input logic [7:0] exp, input int hold);
    sel = s;
    for (int i = 0; i < hold; i++) begin
      chk("tx_req_hold", txr_s, 1);
      chk("tx_byte_hold", txb_s, exp);
      @(negedge clk);
    end
    chk("tx_req", txr_s, 1);
    chk("tx_byte", txb_s, exp);
    if (s) tx_ack1 = 1'b1;
    else   tx_ack0 = 1'b1;
    @(negedge clk);
    tx_ack0 = 1'b0;
    tx_ack1 = 1'b0;
    chk("tx_req_drop", txr_s, 0);
  endtask

  task automatic do_write0(input logic [3:0] a, input logic [7:0] d);
    send(1'b0, 8'h80 | 8'(a));
    chk("wdat_wait_wt", wt_s, 0);
    chk("wdat_wait_err", err_s, 0);
    send(1'b0, d);
    chk("wt_strobe", wt_s, 1);
    chk("wt_rd_low", rd_s, 0);
    chk("wt_adr", adr_s, 5'(a));
    chk("wt_wdat", wdat_s, d);
    ref0[a] = d;
    exp_wt[0]++;
    @(negedge clk);
    chk("wt_single", wt_s, 0);
    chk("no_echo", txr_s, 0);
    chk("wdat_hold", wdat_s, d);
  endtask

  task automatic do_read(input logic s, input logic [4:0] a, input logic [7:0] exp, input int hold);
    send(s, 8'(a));
    chk("rd_strobe", rd_s, 1);
    chk("rd_wt_low", wt_s, 0);
    chk("rd_adr", adr_s, a);
    chk("rd_err", err_s, 0);
    chk("rd_req_low", txr_s, 0);
    exp_rd[s]++;
    @(negedge clk);
    chk("rd_single", rd_s, 0);
    do_ack(s, exp, hold);
  endtask

  task automatic do_invalid0(input logic [7:0] b);
    send(1'b0, b);
    chk("inv_err", err_s, 1);
    chk("inv_wt", wt_s, 0);
    chk("inv_rd", rd_s, 0);
    exp_er[0]++;
    @(negedge clk);
    chk("inv_err_pulse", err_s, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_adr0", adr0, 0);
    chk("rst_wdat0", wdat0, 0);
    chk("rst_txb0", txb0, 0);
    chk("rst_strb0", {wt0, rd0, txr0, err0}, 0);
    chk("rst_adr1", adr1, 0);
    chk("rst_wdat1", wdat1, 0);
    chk("rst_txb1", txb1, 0);
    chk("rst_strb1", {wt1, rd1, txr1, err1}, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref0[i] = bank_init(i);
    for (int i = 0; i < 32; i++) ref1[i] = bank_init(i);
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Directed write then read-back with a stalled transmitter.
    do_write0(4'd3, 8'h5A);
    do_read(1'b0, 5'd3, 8'h5A, 5);

    // Reserved bits set: rejected, then a normal read.
    do_invalid0(8'h13);
    do_read(1'b0, 5'd2, ref0[2], 1);

    // Write command with no data byte following.
    send(1'b0, 8'h81);
    chk("to_wait", err_s, 0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("to_early", err_s, 0);
    end
    @(negedge clk);
    chk("to_err", err_s, 1);
    chk("to_no_wt", wt_s, 0);
    exp_er[0]++;
    @(negedge clk);
    chk("to_err_pulse", err_s, 0);
    do_read(1'b0, 5'd1, ref0[1], 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int op;
      logic [3:0] a;
      logic [7:0] b;
      op = $urandom_range(0, 4);
      a  = 4'($urandom_range(0, 15));
      b  = 8'($urandom_range(0, 255));
      if (op < 2) begin
        do_write0(a, b);
      end else if (op < 4) begin
        do_read(1'b0, 5'(a), ref0[a], $urandom_range(0, 3));
      end else begin
        b[6:4] = 3'($urandom_range(1, 7));
        do_invalid0(b);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Echo configuration: write reply plus an overrun byte while replying.
    send(1'b1, 8'h8F);
    send(1'b1, 8'hC3);
    chk("echo_wt", wt_s, 1);
    chk("echo_adr", adr_s, 5'd15);
    chk("echo_wdat", wdat_s, 8'hC3);
    exp_wt[1]++;
    ref1[15] = 8'hC3;
    @(negedge clk);
    chk("echo_wt_single", wt_s, 0);
    chk("echo_req", txr_s, 1);
    chk("echo_byte", txb_s, 8'hC3);
    send(1'b1, 8'h55);
    chk("overrun_err", err_s, 1);
    exp_er[1]++;
    do_ack(1'b1, 8'hC3, 2);
    chk("overrun_pulse", err_s, 0);
    do_read(1'b1, 5'd15, ref1[15], 1);

    // Reset while waiting for write data.
    send(1'b1, 8'h84);
    chk("rst_in_wdat", wt_s, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) ref1[i] = bank_init(i);
    do_read(1'b1, 5'h11, ref1[17], 1);

    repeat (3) @(negedge clk);
    chk("cnt_wt0", n_wt[0], exp_wt[0]);
    chk("cnt_rd0", n_rd[0], exp_rd[0]);
    chk("cnt_err0", n_er[0], exp_er[0]);
    chk("cnt_wt1", n_wt[1], exp_wt[1]);
    chk("cnt_rd1", n_rd[1], exp_rd[1]);
    chk("cnt_err1", n_er[1], exp_er[1]);
    chk("wt_rd_overlap", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
